// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared opcodes, state encoding and select/fault codes for the
//           Project2 multi-cycle control path.
// Rev     : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [3:0] OP1_ALUR  = 4'b0000;
    localparam logic [3:0] OP1_ALUI  = 4'b1000;
    localparam logic [3:0] OP1_CMPR  = 4'b0010;
    localparam logic [3:0] OP1_CMPI  = 4'b1010;
    localparam logic [3:0] OP1_BCOND = 4'b0110;
    localparam logic [3:0] OP1_SW    = 4'b0101;
    localparam logic [3:0] OP1_LW    = 4'b1001;
    localparam logic [3:0] OP1_JAL   = 4'b1011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_ALU    = 2'd2;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_PC4 = 2'd2;

    localparam logic [1:0] FAULT_NONE        = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL     = 2'd1;
    localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/inst_decoder.sv
`default_nettype none
// ============================================================================
// Module  : inst_decoder
// Brief   : Combinational opcode classifier on the control byte of the IR.
// Rev     : 1.0
// ============================================================================
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir_ctrl,
    output logic [3:0] o_fn,
    output logic       o_is_alu,
    output logic       o_is_cmp,
    output logic       o_is_imm,
    output logic       o_is_br,
    output logic       o_is_lw,
    output logic       o_is_sw,
    output logic       o_is_jal,
    output logic       o_illegal
);

    logic [3:0] w_opcode;

    assign w_opcode = i_ir_ctrl[3:0];
    assign o_fn     = i_ir_ctrl[7:4];

    always_comb begin
        o_is_alu  = 1'b0;
        o_is_cmp  = 1'b0;
        o_is_imm  = 1'b0;
        o_is_br   = 1'b0;
        o_is_lw   = 1'b0;
        o_is_sw   = 1'b0;
        o_is_jal  = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OP1_ALUR:  o_is_alu = 1'b1;
            OP1_ALUI:  begin o_is_alu = 1'b1; o_is_imm = 1'b1; end
            OP1_CMPR:  o_is_cmp = 1'b1;
            OP1_CMPI:  begin o_is_cmp = 1'b1; o_is_imm = 1'b1; end
            OP1_BCOND: o_is_br  = 1'b1;
            OP1_SW:    begin o_is_sw  = 1'b1; o_is_imm = 1'b1; end
            OP1_LW:    begin o_is_lw  = 1'b1; o_is_imm = 1'b1; end
            OP1_JAL:   begin o_is_jal = 1'b1; o_is_imm = 1'b1; end
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath enables.
// Rev     : 1.0
// ============================================================================
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_BITS    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst_word,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic [31:0]         ir,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                reg_we,
    output logic [1:0]          reg_wsel,
    output logic                alu_bsel,
    output logic [3:0]          alu_op,
    output logic                mem_req,
    output logic                mem_we,
    output logic [2:0]          state,
    output logic                halted,
    output logic [1:0]          fault_code,
    output logic [CNT_BITS-1:0] instret
);

    localparam int WAIT_BITS = $clog2(MEM_TIMEOUT + 1);

    state_t                r_state;
    logic [31:0]           r_ir;
    logic [WAIT_BITS-1:0]  r_wait;
    logic [CNT_BITS-1:0]   r_instret;
    logic                  r_halted;
    logic [1:0]            r_fault;

    logic [3:0] w_fn;
    logic       w_is_alu, w_is_cmp, w_is_imm, w_is_br;
    logic       w_is_lw, w_is_sw, w_is_jal, w_illegal;
    logic       w_alu_phase;

    inst_decoder u_dec (
        .i_ir_ctrl (r_ir[7:0]),
        .o_fn      (w_fn),
        .o_is_alu  (w_is_alu),
        .o_is_cmp  (w_is_cmp),
        .o_is_imm  (w_is_imm),
        .o_is_br   (w_is_br),
        .o_is_lw   (w_is_lw),
        .o_is_sw   (w_is_sw),
        .o_is_jal  (w_is_jal),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_wait    <= '0;
            r_instret <= '0;
            r_halted  <= 1'b0;
            r_fault   <= FAULT_NONE;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= inst_word;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_ILLEGAL;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_br) begin
                        r_instret <= r_instret + CNT_BITS'(1);
                        r_state   <= S_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        r_wait  <= '0;
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // A ready strobe in the final allowed cycle still wins over the timeout.
                    if (mem_ready) begin
                        if (w_is_sw) begin
                            r_instret <= r_instret + CNT_BITS'(1);
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (r_wait == WAIT_BITS'(MEM_TIMEOUT - 1)) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_MEM_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + WAIT_BITS'(1);
                    end
                end
                S_WB: begin
                    r_instret <= r_instret + CNT_BITS'(1);
                    r_state   <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // ALU controls stay stable from EXEC through WB so the address/result hold.
    assign w_alu_phase = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    always_comb begin
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_PLUS4;
        reg_we   = 1'b0;
        reg_wsel = WSEL_ALU;
        alu_bsel = 1'b0;
        alu_op   = ALU_ADD;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        if (w_alu_phase) begin
            alu_op   = (w_is_alu || w_is_cmp || w_is_br) ? w_fn : ALU_ADD;
            alu_bsel = w_is_imm;
        end
        case (r_state)
            S_EXEC: begin
                if (w_is_br) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_sw;
                pc_we   = mem_ready && w_is_sw;
            end
            S_WB: begin
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                reg_wsel = w_is_lw ? WSEL_MEM : (w_is_jal ? WSEL_PC4 : WSEL_ALU);
                pc_sel   = w_is_jal ? PC_SEL_ALU : PC_SEL_PLUS4;
            end
            default: ;
        endcase
    end

    assign ir         = r_ir;
    assign state      = r_state;
    assign halted     = r_halted;
    assign fault_code = r_fault;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Random instruction stream scored per retirement, plus fault/reset cases.
// Rev     : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_word;
    logic        br_taken, mem_ready;
    logic [31:0] ir;
    logic        pc_we, reg_we, alu_bsel, mem_req, mem_we, halted;
    logic [1:0]  pc_sel, reg_wsel, fault_code;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_BITS(32)) dut (
        .clk(clk), .reset(reset), .inst_word(inst_word), .br_taken(br_taken),
        .mem_ready(mem_ready), .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .reg_wsel(reg_wsel), .alu_bsel(alu_bsel), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .state(state), .halted(halted),
        .fault_code(fault_code), .instret(instret)
    );

    typedef struct {
        logic [31:0] word;
        logic [1:0]  pc_sel;
        logic        reg_we;
        logic [1:0]  wsel;
        logic [3:0]  aop;
        logic        bsel;
        logic        is_mem;
        logic        mwe;
        int          cycles;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   retired = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // kinds: 0 ALUR 1 ALUI 2 CMPR 3 CMPI 4 BCOND 5 SW 6 LW 7 JAL
    function automatic logic [3:0] opc_of(input int k);
        case (k)
            0: return 4'b0000;
            1: return 4'b1000;
            2: return 4'b0010;
            3: return 4'b1010;
            4: return 4'b0110;
            5: return 4'b0101;
            6: return 4'b1001;
            default: return 4'b1011;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (q.size() > 0) begin
                if (state == 3'd2) begin
                    chk("exec_alu_op", alu_op, q[0].aop);
                    chk("exec_alu_bsel", alu_bsel, q[0].bsel);
                end
                if (mem_req) begin
                    chk("mem_req_kind", mem_req, q[0].is_mem);
                    chk("mem_we", mem_we, q[0].mwe);
                end
            end
            if (reg_we && !pc_we) chk("reg_we_without_pc_we", reg_we, 1'b0);
            if (pc_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_pc_we", pc_we, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("ret_pc_sel", pc_sel, e.pc_sel);
                    chk("ret_reg_we", reg_we, e.reg_we);
                    chk("ret_reg_wsel", reg_wsel, e.wsel);
                    chk("ret_ir", ir, e.word);
                    chk("ret_instret", instret, retired);
                    chk("ret_cycles", cyc, e.cycles);
                    retired++;
                end
                cyc = 0;
            end else if (cyc > 64) begin
                n_vec++;
                n_fail++;
                $display("FAIL retire_timeout: got no pc_we in %0d cycles, required one", cyc);
                if (q.size() > 0) void'(q.pop_front());
                cyc = 0;
            end
        end
    end

    task automatic run_instr(input int kind, input logic [31:0] forced, input bit use_forced);
        exp_t        x;
        logic [31:0] rnd;
        logic [31:0] word;
        logic        br;
        int          w;
        rnd  = $urandom;
        word = use_forced ? forced : {rnd[31:4], opc_of(kind)};
        br   = 1'($urandom_range(0, 1));
        w    = $urandom_range(0, 4);
        x.word   = word;
        x.is_mem = (kind == 5 || kind == 6);
        x.mwe    = (kind == 5);
        x.aop    = (kind >= 5) ? 4'b0000 : word[7:4];
        x.bsel   = (kind == 1 || kind == 3 || kind >= 5);
        x.reg_we = !(kind == 4 || kind == 5);
        x.wsel   = (kind == 6) ? 2'd1 : (kind == 7) ? 2'd2 : 2'd0;
        x.pc_sel = (kind == 4) ? {1'b0, br} : (kind == 7) ? 2'd2 : 2'd0;
        x.cycles = (kind == 4) ? 3 : (kind == 5) ? 4 + w : (kind == 6) ? 5 + w : 4;
        q.push_back(x);
        for (int c = 1; c <= x.cycles; c++) begin
            inst_word = (c == 1) ? word : $urandom;
            br_taken  = (c == 3) ? br : 1'($urandom_range(0, 1));
            if (x.is_mem && c >= 4) mem_ready = (c == 4 + w);
            else                    mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        reset = 1'b0; inst_word = $urandom; br_taken = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_halted_fault", {halted, fault_code}, 3'b000);
        chk("rst_enables", {pc_we, reg_we, mem_req, mem_we}, 4'b0000);
        chk("rst_selects", {pc_sel, reg_wsel, alu_bsel, alu_op}, 9'h000);

        reset  = 1'b1;
        mon_en = 1'b1;
        run_instr(0, 32'h1230_0000, 1'b1);
        for (int i = 0; i < 150; i++) run_instr($urandom_range(0, 7), 32'h0, 1'b0);
        mon_en = 1'b0;
        chk("queue_drained", q.size(), 0);

        // Async reset in the middle of a stalled load.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; inst_word = 32'h1230_0000; mem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        inst_word = 32'h0000_0009;
        repeat (4) @(posedge clk);
        #1;
        chk("midmem_state", state, 3'd3);
        chk("midmem_req", mem_req, 1'b1);
        chk("midmem_instret", instret, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_state", state, 3'd0);
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_instret", instret, 32'd0);
        chk("async_rst_enables", {pc_we, reg_we}, 2'b00);

        // Illegal opcode halts after DECODE.
        @(posedge clk); #1;
        reset = 1'b1; rnd = $urandom; inst_word = {rnd[31:4], 4'hF};
        @(posedge clk); #1;
        inst_word = $urandom;
        @(posedge clk); #1;
        chk("illegal_state", state, 3'd5);
        chk("illegal_halted", halted, 1'b1);
        chk("illegal_fault", fault_code, 2'd1);
        for (int i = 0; i < 6; i++) begin
            inst_word = $urandom; br_taken = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            #3;
            chk("halt_no_enables", {pc_we, reg_we, mem_req, mem_we}, 4'b0000);
            chk("halt_hold", {state, fault_code}, {3'd5, 2'd1});
            @(posedge clk); #1;
        end

        // Store that never completes times out after 16 MEM cycles.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; rnd = $urandom; inst_word = {rnd[31:4], 4'b0101}; mem_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 19) chk("timeout_last_mem", {state, mem_req}, {3'd3, 1'b1});
            if (c == 20) begin
                chk("timeout_state", state, 3'd5);
                chk("timeout_fault", {halted, fault_code}, {1'b1, 2'd2});
            end
            if (c < 20) begin
                @(posedge clk); #1;
                inst_word = $urandom;
            end
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            chk("timeout_frozen", {pc_we, mem_req, fault_code}, {1'b0, 1'b0, 2'd2});
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
